// File: rtl/wb_write_arbiter_if.sv
// Write-back port bundle: MEM/WB request, LU result handshake, regfile write
// outputs and decode pending-write queries.
interface wb_write_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_waddr;
    logic [DW-1:0] lu_wdata;
    logic          stallreq;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] qaddr1;
    logic [AW-1:0] qaddr2;
    logic          qbusy1;
    logic          qbusy2;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, qaddr1, qaddr2,
        input  lu_ready, stallreq, we, waddr, wdata, qbusy1, qbusy2
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, qaddr1, qaddr2,
        output lu_ready, stallreq, we, waddr, wdata, qbusy1, qbusy2
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single regfile write-port arbiter: in-order pipeline write-backs merged with
// queued long-latency results, with starvation stall and pending-write queries.
module wb_write_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32
) (
    input logic              clk,
    input logic              rst,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic          vld_q  [DEPTH];
    logic          vld_d  [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, widx;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic empty, full, stall, pipe_req, pipe_take, pop, push;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign stall     = (starve_q == SW'(STARVE_MAX)) && !empty;
    assign pipe_req  = bus.pipe_we && (bus.pipe_waddr != '0);
    assign pipe_take = pipe_req && !stall;
    assign pop       = !empty && (stall || !pipe_req);
    assign push      = bus.lu_valid && !full;

    always_comb begin
        vld_d    = vld_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        widx     = cnt_q;

        if (pipe_take) begin
            we_d    = 1'b1;
            waddr_d = bus.pipe_waddr;
            wdata_d = bus.pipe_wdata;
            // The pipe write is newer than anything queued for the same register.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == bus.pipe_waddr) vld_d[i] = 1'b0;
            end
        end else if (pop) begin
            we_d = vld_q[0];
            if (vld_q[0]) begin
                waddr_d = addr_q[0];
                wdata_d = data_q[0];
            end
        end

        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                vld_d[i]  = vld_d[i+1];
                addr_d[i] = addr_d[i+1];
                data_d[i] = data_d[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
            widx = cnt_q - CW'(1);
        end

        // Enqueue lands after invalidation so a same-cycle LU result stays valid.
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == widx) begin
                    vld_d[i]  = (bus.lu_waddr != '0);
                    addr_d[i] = bus.lu_waddr;
                    data_d[i] = bus.lu_wdata;
                end
            end
        end

        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        if (pop || empty)   starve_d = '0;
        else if (pipe_take) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            cnt_q    <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    logic busy1, busy2;

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && vld_q[i]) begin
                if (addr_q[i] == bus.qaddr1) busy1 = 1'b1;
                if (addr_q[i] == bus.qaddr2) busy2 = 1'b1;
            end
        end
    end

    assign bus.qbusy1   = busy1 && (bus.qaddr1 != '0);
    assign bus.qbusy2   = busy2 && (bus.qaddr2 != '0);
    assign bus.lu_ready = !full;
    assign bus.stallreq = stall;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned AW         = 5;
    localparam int unsigned DW         = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_write_arbiter #(
        .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Regfile image built from what the DUT actually writes.
    logic [DW-1:0] rf [32];
    always @(posedge clk) if (bus.we) rf[bus.waddr] <= bus.wdata;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ok;
    } ent_t;

    ent_t          mq[$];
    int            m_starve;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            vectors;
    int            miscompares;

    function automatic bit m_stall();
        return (m_starve == STARVE_MAX) && (mq.size() > 0);
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].ok && mq[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the reference model on the current inputs, then clock the DUT.
    task automatic tick();
        bit   stall = m_stall();
        bit   pr    = bus.pipe_we && (bus.pipe_waddr != 0);
        bit   push  = bus.lu_valid && m_ready();
        ent_t e;
        if (rst) begin
            mq.delete();
            m_starve = 0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_we = 1'b0;
            if (!stall && pr) begin
                m_we = 1'b1; m_waddr = bus.pipe_waddr; m_wdata = bus.pipe_wdata;
                foreach (mq[i]) if (mq[i].a == bus.pipe_waddr) mq[i].ok = 1'b0;
                if (mq.size() > 0) m_starve++;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_starve = 0;
                if (e.ok) begin
                    m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
                end
            end
            if (push) mq.push_back('{a: bus.lu_waddr, d: bus.lu_wdata, ok: (bus.lu_waddr != 0)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bus.pipe_we = pwe; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
        bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.qaddr1 = 5'd3; bus.qaddr2 = 5'd0;
        tick(); tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_out we=%b waddr=%0d wdata=%h expected 0/0/0", bus.we, bus.waddr, bus.wdata);
        end
        vectors++;
        if ({bus.lu_ready, bus.stallreq, bus.qbusy1, bus.qbusy2} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags ready/stall/qb1/qb2=%b%b%b%b expected 1000",
                     bus.lu_ready, bus.stallreq, bus.qbusy1, bus.qbusy2);
        end
        rst = 1'b0;
    endtask

    task automatic test_pipe_write();
        drive(1, 5, 32'h11, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'h11}) begin
            miscompares++;
            $display("FAIL pipe_write we=%b waddr=%0d wdata=%h expected 1/5/11", bus.we, bus.waddr, bus.wdata);
        end
        drive(1, 0, 32'h99, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 5'd5, 32'h11}) begin
            miscompares++;
            $display("FAIL pipe_r0 we=%b waddr=%0d wdata=%h expected 0/5/11", bus.we, bus.waddr, bus.wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_lu_pop();
        drive(0, 0, 0, 1, 7, 32'hAB);
        bus.qaddr1 = 5'd7; bus.qaddr2 = 5'd8;
        #1;
        vectors++;
        if (bus.qbusy1 !== 1'b0) begin
            miscompares++; $display("FAIL lu_busy_pre qbusy1=%b expected 0", bus.qbusy1);
        end
        tick();
        vectors++;
        if ({bus.we, bus.qbusy1, bus.qbusy2} !== 3'b010) begin
            miscompares++;
            $display("FAIL lu_queued we/qb1/qb2=%b%b%b expected 010", bus.we, bus.qbusy1, bus.qbusy2);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata, bus.qbusy1} !== {1'b1, 5'd7, 32'hAB, 1'b0}) begin
            miscompares++;
            $display("FAIL lu_pop we=%b waddr=%0d wdata=%h qbusy1=%b expected 1/7/ab/0",
                     bus.we, bus.waddr, bus.wdata, bus.qbusy1);
        end
    endtask

    task automatic test_starve();
        drive(1, 10, 32'h100, 1, 9, 32'h900);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 5'(10 + k), 32'(32'h100 + k), 0, 0, 0);
            #1;
            vectors++;
            if (bus.stallreq !== 1'b0) begin
                miscompares++; $display("FAIL starve_early k=%0d stallreq=%b expected 0", k, bus.stallreq);
            end
            tick();
        end
        vectors++;
        if (bus.stallreq !== 1'b1) begin
            miscompares++; $display("FAIL starve_raise stallreq=%b expected 1", bus.stallreq);
        end
        drive(1, 15, 32'h115, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata, bus.stallreq} !== {1'b1, 5'd9, 32'h900, 1'b0}) begin
            miscompares++;
            $display("FAIL starve_lu_win we=%b waddr=%0d wdata=%h stall=%b expected 1/9/900/0",
                     bus.we, bus.waddr, bus.wdata, bus.stallreq);
        end
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd15, 32'h115}) begin
            miscompares++;
            $display("FAIL starve_held_pipe we=%b waddr=%0d wdata=%h expected 1/15/115",
                     bus.we, bus.waddr, bus.wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_invalidate();
        drive(1, 4, 32'h44, 1, 3, 32'h33);
        bus.qaddr1 = 5'd3;
        tick();
        vectors++;
        if (bus.qbusy1 !== 1'b1) begin
            miscompares++; $display("FAIL inv_queued qbusy1=%b expected 1", bus.qbusy1);
        end
        drive(1, 3, 32'h22, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata, bus.qbusy1} !== {1'b1, 5'd3, 32'h22, 1'b0}) begin
            miscompares++;
            $display("FAIL inv_pipe we=%b waddr=%0d wdata=%h qbusy1=%b expected 1/3/22/0",
                     bus.we, bus.waddr, bus.wdata, bus.qbusy1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 5'd3, 32'h22} || rf[3] !== 32'h22) begin
            miscompares++;
            $display("FAIL inv_pop we=%b waddr=%0d wdata=%h r3=%h expected 0/3/22 r3=22",
                     bus.we, bus.waddr, bus.wdata, rf[3]);
        end
        tick();
    endtask

    task automatic test_full();
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 5'd20; exp_a[1] = 5'd21; exp_a[2] = 5'd22;
        drive(1, 1, 32'h1, 1, 20, 32'hA20);
        tick();
        drive(1, 2, 32'h2, 1, 21, 32'hA21);
        tick();
        drive(1, 1, 32'h3, 1, 22, 32'hA22);
        #1;
        vectors++;
        if (bus.lu_ready !== 1'b0) begin
            miscompares++; $display("FAIL full_ready lu_ready=%b expected 0", bus.lu_ready);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) drive(0, 0, 0, 1, 22, 32'hA22);
            else       drive(0, 0, 0, 0, 0, 0);
            #1;
            if (k < 2) begin
                vectors++;
                if (bus.lu_ready !== (k == 1)) begin
                    miscompares++;
                    $display("FAIL full_ready_k%0d lu_ready=%b expected %0d", k, bus.lu_ready, k == 1);
                end
            end
            tick();
            vectors++;
            if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, exp_a[k], 32'(32'hA00 + 32'h20 + k)}) begin
                miscompares++;
                $display("FAIL full_order k=%0d we=%b waddr=%0d wdata=%h expected 1/%0d/%h",
                         k, bus.we, bus.waddr, bus.wdata, exp_a[k], 32'hA20 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 32'h1, 1, 12, 32'hC12);
        tick();
        drive(1, 2, 32'h2, 1, 13, 32'hC13);
        tick();
        for (int k = 3; k <= 5; k++) begin
            drive(1, 5'(k), 32'(k), 0, 0, 0);
            tick();
        end
        bus.qaddr1 = 5'd12; bus.qaddr2 = 5'd13;
        #1;
        vectors++;
        if ({bus.stallreq, bus.lu_ready, bus.qbusy1, bus.qbusy2} !== 4'b1011) begin
            miscompares++;
            $display("FAIL rstmid_pre stall/ready/qb1/qb2=%b%b%b%b expected 1011",
                     bus.stallreq, bus.lu_ready, bus.qbusy1, bus.qbusy2);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.we, bus.waddr, bus.wdata, bus.lu_ready, bus.stallreq, bus.qbusy1, bus.qbusy2}
            !== {1'b0, 5'd0, 32'd0, 4'b1000}) begin
            miscompares++;
            $display("FAIL rstmid we=%b waddr=%0d wdata=%h ready/stall/qb1/qb2=%b%b%b%b expected 0/0/0 1000",
                     bus.we, bus.waddr, bus.wdata, bus.lu_ready, bus.stallreq, bus.qbusy1, bus.qbusy2);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (!m_stall()) begin
                bus.pipe_we    = ($urandom_range(0, 99) < 60);
                bus.pipe_waddr = 5'($urandom_range(0, 7));
                bus.pipe_wdata = $urandom;
            end
            if (!(bus.lu_valid && !m_ready())) begin
                bus.lu_valid = ($urandom_range(0, 99) < 40);
                bus.lu_waddr = 5'($urandom_range(0, 7));
                bus.lu_wdata = $urandom;
            end
            bus.qaddr1 = 5'($urandom_range(0, 7));
            bus.qaddr2 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            #1;
            vectors++;
            if ({bus.stallreq, bus.lu_ready, bus.qbusy1, bus.qbusy2}
                !== {m_stall(), m_ready(), m_busy(bus.qaddr1), m_busy(bus.qaddr2)}) begin
                miscompares++;
                $display("FAIL rand_flags n=%0d stall/ready/qb1/qb2=%b%b%b%b expected %b%b%b%b", n,
                         bus.stallreq, bus.lu_ready, bus.qbusy1, bus.qbusy2,
                         m_stall(), m_ready(), m_busy(bus.qaddr1), m_busy(bus.qaddr2));
            end
            tick();
            vectors++;
            if ({bus.we, bus.waddr, bus.wdata} !== {m_we, m_waddr, m_wdata}) begin
                miscompares++;
                $display("FAIL rand_write n=%0d we=%b waddr=%0d wdata=%h expected %b/%0d/%h",
                         n, bus.we, bus.waddr, bus.wdata, m_we, m_waddr, m_wdata);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_starve    = 0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        test_reset();
        test_pipe_write();
        test_lu_pop();
        test_starve();
        test_invalidate();
        test_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
